// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential switch/key calculator: modes,
// per-mode operation selects and controller states.
package seq_alu_pkg;

   typedef enum logic [1:0] {
      MODE_ARITH = 2'd0,
      MODE_LOGIC = 2'd1,
      MODE_CMP   = 2'd2,
      MODE_PASS  = 2'd3
   } mode_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   localparam logic [1:0] OP_EQ  = 2'b00;
   localparam logic [1:0] OP_GT  = 2'b01;
   localparam logic [1:0] OP_LT  = 2'b10;
   localparam logic [1:0] OP_MAX = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ITER = 2'd2
   } state_e;

endpackage

// File: rtl/seq_alu_calc_key_debounce.sv
// Debouncer for one active-low board key: two-flop synchroniser, run-length
// counter against the stable level, and a one-cycle pulse on each accepted press.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_sample;

   assign w_sample = ~r_sync2;
   assign o_press  = r_press;

   // Synchronise, count consecutive disagreeing samples, flip the stable level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b0;
         r_press  <= 1'b0;
         r_cnt    <= {CNT_W{1'b0}};
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (w_sample != r_stable) begin
            if (r_cnt == CNT_LAST) begin
               r_stable <= w_sample;
               r_cnt    <= {CNT_W{1'b0}};
               r_press  <= w_sample;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= {CNT_W{1'b0}};
         end
      end
   end

endmodule

// File: rtl/seq_alu_calc.sv
// Clocked calculator datapath between the board switches/keys and the display
// layer: mode stepping, single-cycle ops and iterative multiply/divide.
module seq_alu_calc
   import seq_alu_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           key_n,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic [1:0]           op_sel,
   output logic [1:0]           mode,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ovf,
   output logic                 dz_err,
   output logic                 busy,
   output logic                 valid
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   state_e            r_state;
   state_e            w_next_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [1:0]        r_sel;
   logic [1:0]        r_lmode;
   logic [1:0]        r_mode;
   logic [RW-1:0]     r_result;
   logic              r_ovf;
   logic              r_dz;
   logic              r_busy;
   logic              r_valid;
   logic [RW-1:0]     r_acc;
   logic [RW-1:0]     r_mcand;
   logic [WIDTH-1:0]  r_mplier;
   logic [WIDTH-1:0]  r_rem;
   logic [WIDTH-1:0]  r_quo;
   logic [CW-1:0]     r_iter;

   logic              w_start_press;
   logic              w_mode_press;
   logic              w_go_iter;
   logic              w_iter_last;
   logic [WIDTH-1:0]  w_sum;
   logic [WIDTH-1:0]  w_diff;
   logic [RW-1:0]     w_exec_result;
   logic              w_exec_ovf;
   logic              w_exec_dz;
   logic [RW-1:0]     w_mul_acc_next;
   logic [WIDTH:0]    w_div_shift;
   logic              w_div_ge;
   logic [WIDTH-1:0]  w_div_rem_next;
   logic [WIDTH-1:0]  w_div_quo_next;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_key_n (key_n[0]),
      .o_press (w_start_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_key_n (key_n[1]),
      .o_press (w_mode_press)
   );

   // Divide by zero never iterates; it completes through EXEC with the error flag.
   assign w_go_iter   = (r_mode == MODE_ARITH) &&
                        ((op_sel == OP_MUL) || ((op_sel == OP_DIV) && (op_b != {WIDTH{1'b0}})));
   assign w_iter_last = (r_iter == CW'(WIDTH - 1));
   assign w_sum       = r_a + r_b;
   assign w_diff      = r_a - r_b;

   assign w_mul_acc_next = r_acc + (r_mplier[0] ? r_mcand : {RW{1'b0}});
   assign w_div_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_div_ge       = (w_div_shift >= {1'b0, r_b});
   assign w_div_rem_next = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_b}) : w_div_shift[WIDTH-1:0];
   assign w_div_quo_next = {r_quo[WIDTH-2:0], w_div_ge};

   assign mode   = r_mode;
   assign result = r_result;
   assign ovf    = r_ovf;
   assign dz_err = r_dz;
   assign busy   = r_busy;
   assign valid  = r_valid;

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Controller next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_press) begin
               w_next_state = w_go_iter ? ST_ITER : ST_EXEC;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXEC: w_next_state = ST_IDLE;
         ST_ITER: begin
            if (w_iter_last) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_ITER;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Single-cycle results from the latched operands.
   always_comb begin
      w_exec_result = {RW{1'b0}};
      w_exec_ovf    = 1'b0;
      w_exec_dz     = 1'b0;
      case (r_lmode)
         MODE_ARITH: begin
            case (r_sel)
               OP_ADD: begin
                  w_exec_result = {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
                  w_exec_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
               end
               OP_SUB: begin
                  w_exec_result = {{WIDTH{w_diff[WIDTH-1]}}, w_diff};
                  w_exec_ovf    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
               end
               OP_DIV: begin
                  w_exec_result = {RW{1'b1}};
                  w_exec_dz     = 1'b1;
               end
               default: w_exec_result = {RW{1'b0}};
            endcase
         end
         MODE_LOGIC: begin
            case (r_sel)
               OP_AND:  w_exec_result = {{WIDTH{1'b0}}, r_a & r_b};
               OP_OR:   w_exec_result = {{WIDTH{1'b0}}, r_a | r_b};
               OP_XOR:  w_exec_result = {{WIDTH{1'b0}}, r_a ^ r_b};
               default: w_exec_result = {{WIDTH{1'b0}}, ~r_a};
            endcase
         end
         MODE_CMP: begin
            case (r_sel)
               OP_EQ:   w_exec_result = {{(RW-1){1'b0}}, (r_a == r_b)};
               OP_GT:   w_exec_result = {{(RW-1){1'b0}}, (r_a > r_b)};
               OP_LT:   w_exec_result = {{(RW-1){1'b0}}, (r_a < r_b)};
               default: w_exec_result = {{WIDTH{1'b0}}, ((r_a > r_b) ? r_a : r_b)};
            endcase
         end
         MODE_PASS: w_exec_result = {r_b, r_a};
         default:   w_exec_result = {RW{1'b0}};
      endcase
   end

   // Operand latch, mode stepping, iteration datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= {WIDTH{1'b0}};
         r_b      <= {WIDTH{1'b0}};
         r_sel    <= 2'b00;
         r_lmode  <= 2'b00;
         r_mode   <= 2'b00;
         r_result <= {RW{1'b0}};
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_acc    <= {RW{1'b0}};
         r_mcand  <= {RW{1'b0}};
         r_mplier <= {WIDTH{1'b0}};
         r_rem    <= {WIDTH{1'b0}};
         r_quo    <= {WIDTH{1'b0}};
         r_iter   <= {CW{1'b0}};
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start_press) begin
                  r_a      <= op_a;
                  r_b      <= op_b;
                  r_sel    <= op_sel;
                  r_lmode  <= r_mode;
                  r_busy   <= 1'b1;
                  r_acc    <= {RW{1'b0}};
                  r_mcand  <= {{WIDTH{1'b0}}, op_a};
                  r_mplier <= op_b;
                  r_rem    <= {WIDTH{1'b0}};
                  r_quo    <= op_a;
                  r_iter   <= {CW{1'b0}};
               end else if (w_mode_press) begin
                  r_mode <= r_mode + 2'd1;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_EXEC: begin
               r_result <= w_exec_result;
               r_ovf    <= w_exec_ovf;
               r_dz     <= w_exec_dz;
               r_valid  <= 1'b1;
               r_busy   <= 1'b0;
            end
            ST_ITER: begin
               r_acc    <= w_mul_acc_next;
               r_mcand  <= {r_mcand[RW-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
               r_rem    <= w_div_rem_next;
               r_quo    <= w_div_quo_next;
               r_iter   <= r_iter + CW'(1);
               if (w_iter_last) begin
                  r_result <= (r_sel == OP_MUL) ? w_mul_acc_next : {w_div_rem_next, w_div_quo_next};
                  r_ovf    <= 1'b0;
                  r_dz     <= 1'b0;
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b0;
               end
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/seq_alu_calc.md
Name: seq_alu_calc

Overview:
- Parametrised, clocked successor to the switch/key calculator datapath.
- Debounces the two board keys. One key cycles the mode (arithmetic, logical, comparison, pass-through); the other starts a computation.
- Performs WIDTH-bit operations, with iterative multi-cycle multiply and divide.
- Holds a registered 2*WIDTH-bit result plus status flags for the display/LED layer. Sits between the board I/O and the seven-segment/LED drivers.

Parameters:
- WIDTH, 4, operand width in bits (2..16).
- DEBOUNCE_CYCLES, 50000, consecutive identical synchronised samples needed to accept a key level change (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key_n  input  2  raw active-low keys; [0]=start, [1]=mode step.
- op_a  input  WIDTH  operand A (switches).
- op_b  input  WIDTH  operand B (switches).
- op_sel  input  2  operation within the mode.
- mode  output  2  current mode: 0 arith, 1 logic, 2 compare, 3 pass.
- result  output  2*WIDTH  registered result.
- ovf  output  1  signed overflow (add/sub only).
- dz_err  output  1  divide by zero.
- busy  output  1  computation in progress.
- valid  output  1  one-cycle pulse when result/flags update.

Behaviour:
- Reset values: mode=0, result=0, ovf=0, dz_err=0, busy=0, valid=0, FSM=IDLE. Debouncers report "released" on reset.
- Key path: 2-FF synchroniser, then debounce counter.
  - The stable level changes only after DEBOUNCE_CYCLES consecutive samples differing from the current stable level.
  - Any equal sample clears the counter.
  - press pulse = 1 cycle on a stable released->pressed transition.
- Mode step:
  - press on key[1] in IDLE: mode <= mode+1, wrapping 3->0.
  - Presses while busy are dropped, not queued.
- FSM states: IDLE, EXEC, ITER.
  - IDLE, on start press: latch op_a, op_b, op_sel and mode into internal registers; busy<=1. Goes to ITER for arith mul/div, otherwise to EXEC.
  - EXEC: write result and flags, valid<=1, busy<=0, go to IDLE. Latency: start press at edge E -> valid at edge E+2.
  - ITER: WIDTH iterations, one per cycle. The final iteration writes result, valid<=1, busy<=0, goes to IDLE. Latency: valid at edge E+1+WIDTH.
- Start pressed while busy: ignored. Switch changes after the latch do not affect the operation in progress.
- Arith (mode 0); operands are two's complement for add/sub, unsigned for mul/div:
  - op_sel 00, add: result = sign-extended WIDTH-bit sum.
  - op_sel 01, sub A-B: result = sign-extended WIDTH-bit difference.
  - For add/sub, ovf=1 when operand signs agree (add) or differ (sub) and the result sign differs from A.
  - op_sel 10, mul: unsigned shift-add, full 2*WIDTH product.
  - op_sel 11, div: unsigned restoring division; result = {remainder, quotient}.
  - B==0: no iteration; result = all ones, dz_err=1, finishes via EXEC latency (E+2).
- Logic (mode 1): op_sel 00 AND, 01 OR, 10 XOR, 11 NOT A. Result is zero-extended.
- Compare (mode 2), unsigned: op_sel 00 A==B, 01 A>B, 10 A<B, 11 max(A,B). Boolean results occupy bit 0, zero-extended.
- Pass (mode 3): result = {B, A}.
- Flag scope: ovf and dz_err are cleared on every completion that does not set them. Flags are held until the next valid.
- rst mid-operation: returns to IDLE at once; result and flags are cleared, no valid pulse.

Decomposition:
- Shared package seq_alu_pkg:
  - mode encodings MODE_ARITH/LOGIC/CMP/PASS.
  - op_sel encodings per mode.
  - FSM state encoding.
- One sub-module: key_debounce (synchroniser, counter, stable level, press pulse), instantiated once per key with DEBOUNCE_CYCLES passed through.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4):
1. mode 0, op_sel 00, A=7, B=1, start -> valid 2 cycles after press pulse; result=8'hF8, ovf=1. Then A=3, B=2 -> result=8'h05, ovf=0.
2. mode 0, op_sel 10, A=15, B=15 -> busy for 5 cycles; valid at press+5; result=8'hE1.
3. mode 0, op_sel 11, A=13, B=4 -> result=8'h13, dz_err=0. Then B=0 -> result=8'hFF, dz_err=1, valid at press+2.
4. Key bounce: 3-cycle low glitches on key_n[1] -> mode unchanged. Four clean presses -> mode 1, 2, 3, 0.
5. mode 2, op_sel 11, A=5, B=9 -> result=8'h09. Then mode 3 -> result=8'h95.
6. Start mul, then press start and mode during ITER -> both ignored, one valid pulse only. Assert rst at iteration 2 -> busy=0, result=0, mode=0, no valid.
